// File: rtl/tcp_chan_arbiter_pkg.sv
// Shared state encoding and round-robin index helpers for the TCP channel arbiter
// and the reusable rr_select search block.
package tcp_chan_arbiter_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    // Explicit compare-and-subtract wrap so channel counts that are not powers of two work.
    function automatic int unsigned wrap_add(input int unsigned base,
                                             input int unsigned offset,
                                             input int unsigned count);
        int unsigned sum;
        sum = base + offset;
        if (sum >= count) begin
            return sum - count;
        end else begin
            return sum;
        end
    endfunction

    function automatic int unsigned next_rr(input int unsigned idx, input int unsigned count);
        return wrap_add(idx, 32'd1, count);
    endfunction

endpackage

// File: rtl/tcp_chan_arbiter_rr_select.sv
// rr_select: combinational search for the first set request bit at or after ptr,
// wrapping at NUM_CH. Returns the winner as one-hot and as an index, plus an any flag.
module rr_select
    import tcp_chan_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_CH-1:0]    req,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic [NUM_CH-1:0]    onehot,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    // Walk positions ptr, ptr+1, ... and latch the first requester found
    always_comb begin
        int unsigned pos;
        logic        hit;
        onehot = {NUM_CH{1'b0}};
        idx    = {IDX_WIDTH{1'b0}};
        any    = 1'b0;
        pos    = 32'd0;
        hit    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            pos = wrap_add(32'(ptr), 32'(k), 32'(NUM_CH));
            for (int i = 0; i < NUM_CH; i++) begin
                hit       = !any && (pos == 32'(i)) && req[i];
                onehot[i] = onehot[i] | hit;
                idx       = hit ? IDX_WIDTH'(i) : idx;
                any       = any | hit;
            end
        end
    end

endmodule

// File: rtl/tcp_chan_arbiter.sv
// tcp_chan_arbiter: packet-granular round-robin mux of NUM_CH requesters onto one TCP
// bridge, plus a return-path demux. Optional stall watchdog: TCP_CHAN_ARBITER_TIMEOUT_EN.
module tcp_chan_arbiter
    import tcp_chan_arbiter_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int DEST_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            s_valid,
    output logic [NUM_CH-1:0]            s_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] s_data,
    input  logic [NUM_CH-1:0]            s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [DATA_WIDTH-1:0]        m_data,
    output logic                         m_last,
    output logic [DEST_WIDTH-1:0]        m_dest,
    input  logic                         r_valid,
    output logic                         r_ready,
    input  logic [DATA_WIDTH-1:0]        r_data,
    input  logic [DEST_WIDTH-1:0]        r_dest,
    output logic [NUM_CH-1:0]            o_valid,
    input  logic [NUM_CH-1:0]            o_ready,
    output logic [DATA_WIDTH-1:0]        o_data,
    output logic                         busy,
    output logic                         timeout_pulse
);

    arb_state_t              state_r, next_state_s;
    logic [DEST_WIDTH-1:0]   grant_r, rr_ptr_r, sel_idx_s;
    logic [NUM_CH-1:0]       grant_oh_r, sel_oh_s;
    logic                    sel_any_s;
    logic                    g_valid_s, g_last_s;
    logic [DATA_WIDTH-1:0]   g_data_s;
    logic                    release_s, timeout_fire_s;

    rr_select #(
        .NUM_CH    (NUM_CH),
        .IDX_WIDTH (DEST_WIDTH)
    ) u_rr_select (
        .req    (s_valid),
        .ptr    (rr_ptr_r),
        .onehot (sel_oh_s),
        .idx    (sel_idx_s),
        .any    (sel_any_s)
    );

    // Mux the granted channel's beat out of the packed request buses
    always_comb begin
        logic sel;
        g_valid_s = 1'b0;
        g_last_s  = 1'b0;
        g_data_s  = {DATA_WIDTH{1'b0}};
        sel       = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel       = (grant_r == DEST_WIDTH'(i));
            g_valid_s = g_valid_s | (sel & s_valid[i]);
            g_last_s  = g_last_s | (sel & s_last[i]);
            g_data_s  = sel ? s_data[i*DATA_WIDTH +: DATA_WIDTH] : g_data_s;
        end
    end

    assign release_s = ((state_r == LOCK) && g_valid_s && m_ready && g_last_s) || timeout_fire_s;

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            grant_r    <= {DEST_WIDTH{1'b0}};
            grant_oh_r <= {NUM_CH{1'b0}};
            rr_ptr_r   <= {DEST_WIDTH{1'b0}};
        end else begin
            state_r <= next_state_s;
            if ((state_r == IDLE) && sel_any_s) begin
                grant_r    <= sel_idx_s;
                grant_oh_r <= sel_oh_s;
            end else begin
                grant_r    <= grant_r;
                grant_oh_r <= grant_oh_r;
            end
            if (release_s) begin
                rr_ptr_r <= DEST_WIDTH'(next_rr(32'(grant_r), 32'(NUM_CH)));
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    // Next-state: one IDLE cycle per arbitration, hold LOCK until release
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    next_state_s = sel_any_s ? LOCK : IDLE;
            LOCK:    next_state_s = release_s ? IDLE : LOCK;
            default: next_state_s = IDLE;
        endcase
    end

    // Transmit outputs: combinational pass-through of the granted channel while locked
    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        s_ready = {NUM_CH{1'b0}};
        busy    = 1'b0;
        if (state_r == LOCK) begin
            m_valid = g_valid_s;
            m_last  = g_last_s;
            s_ready = m_ready ? grant_oh_r : {NUM_CH{1'b0}};
            busy    = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
    end

    assign m_data = g_data_s;
    assign m_dest = grant_r;

    // Return demux; out-of-range destinations are swallowed with r_ready high
    always_comb begin
        logic dest_ok;
        logic hit;
        logic sel_ready;
        dest_ok   = (32'(r_dest) < 32'(NUM_CH));
        hit       = 1'b0;
        sel_ready = 1'b0;
        o_valid   = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            hit        = dest_ok && (r_dest == DEST_WIDTH'(i));
            o_valid[i] = hit & r_valid & !rst;
            sel_ready  = hit ? o_ready[i] : sel_ready;
        end
        if (rst) begin
            r_ready = 1'b0;
        end else begin
            r_ready = dest_ok ? sel_ready : 1'b1;
        end
    end

    assign o_data = r_data;

`ifdef TCP_CHAN_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] stall_cnt_r;
    logic             timeout_pulse_r;

    // The limit is hit on the stalled cycle that would bring the count to TIMEOUT_CYCLES
    assign timeout_fire_s = (state_r == LOCK) && !g_valid_s &&
                            (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Stall counter and one-cycle timeout pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r     <= {CNT_W{1'b0}};
            timeout_pulse_r <= 1'b0;
        end else begin
            timeout_pulse_r <= timeout_fire_s;
            if ((state_r != LOCK) || timeout_fire_s || (g_valid_s && m_ready)) begin
                stall_cnt_r <= {CNT_W{1'b0}};
            end else if (!g_valid_s) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign timeout_pulse = timeout_pulse_r;
`else
    assign timeout_fire_s = 1'b0;
    assign timeout_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_tcp_chan_arbiter.sv
// Self-checking bench for tcp_chan_arbiter: directed scenarios plus randomized traffic
// compared against a packet-level round-robin reference model.
module tb_tcp_chan_arbiter;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int DSW = 2;
`ifdef TCP_CHAN_ARBITER_TIMEOUT_EN
    localparam int TO  = 8;
`else
    localparam int TO  = 256;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    s_valid, s_ready, s_last;
    logic [N*DW-1:0] s_data;
    logic            m_valid, m_ready, m_last;
    logic [DW-1:0]   m_data;
    logic [DSW-1:0]  m_dest;
    logic            r_valid, r_ready;
    logic [DW-1:0]   r_data, o_data;
    logic [DSW-1:0]  r_dest;
    logic [N-1:0]    o_valid, o_ready;
    logic            busy, timeout_pulse;

    always #5 clk = ~clk;

    tcp_chan_arbiter #(
        .NUM_CH(N), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_dest(m_dest),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_dest(r_dest),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    int checks = 0;
    int errors = 0;

    // Requester side: one queue of pending beats {last, data} per channel
    logic [DW:0]     q [N][$];
    logic [N-1:0]    hold;
    int              gap_pct;
    logic [DW+DSW:0] obs_log [$];

    // Reference model: who owns the bridge (-1 = nobody) and where the search starts
    int              mdl_owner, mdl_ptr;
    logic            exp_m_valid, exp_busy, exp_r_ready;
    logic [N-1:0]    exp_s_ready, exp_o_valid;
    logic [DW+DSW:0] exp_pay, obs_pay;

    task automatic drive_sources();
        for (int c = 0; c < N; c++) begin
            if (q[c].size() > 0 && !hold[c] && (int'($urandom_range(99)) >= gap_pct)) begin
                s_valid[c]         = 1'b1;
                s_last[c]          = q[c][0][DW];
                s_data[c*DW +: DW] = q[c][0][DW-1:0];
            end else begin
                s_valid[c]         = 1'b0;
                s_last[c]          = 1'($urandom_range(1));
                s_data[c*DW +: DW] = $urandom;
            end
        end
    endtask

    // Drive this cycle's requests, then at the falling edge compute what the bridge should see
    task automatic step_pre();
        drive_sources();
        @(negedge clk);
        exp_busy    = (mdl_owner >= 0);
        exp_m_valid = 1'b0;
        exp_s_ready = {N{1'b0}};
        exp_pay     = {(DW+DSW+1){1'b0}};
        if (mdl_owner >= 0) begin
            exp_m_valid            = s_valid[mdl_owner];
            exp_s_ready[mdl_owner] = m_ready;
            if (exp_m_valid)
                exp_pay = {s_last[mdl_owner], DSW'(mdl_owner), s_data[mdl_owner*DW +: DW]};
        end
        exp_o_valid = {N{1'b0}};
        exp_r_ready = 1'b1;
        if (int'(r_dest) < N) begin
            exp_o_valid[r_dest] = r_valid;
            exp_r_ready         = o_ready[r_dest];
        end
        obs_pay = m_valid ? {m_last, m_dest, m_data} : {(DW+DSW+1){1'b0}};
        if (m_valid && m_ready) obs_log.push_back(obs_pay);
    endtask

    // Advance the reference model across the rising edge and retire accepted beats
    task automatic step_post();
        logic [N-1:0] acc;
        acc = s_valid & exp_s_ready;
        if (mdl_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c = (mdl_ptr + k) % N;
                if (mdl_owner < 0 && s_valid[c]) mdl_owner = c;
            end
        end else if (s_valid[mdl_owner] && m_ready && s_last[mdl_owner]) begin
            mdl_ptr   = (mdl_owner + 1) % N;
            mdl_owner = -1;
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++)
            if (acc[c]) void'(q[c].pop_front());
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = {N{1'b0}};
        hold    = {N{1'b0}};
        for (int c = 0; c < N; c++) q[c].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mdl_owner = -1;
        mdl_ptr   = 0;
    endtask

    task automatic test_reset();
        s_valid = {N{1'b1}};
        s_last  = {N{1'b1}};
        m_ready = 1'b1;
        r_valid = 1'b1;
        r_dest  = 2'd1;
        o_ready = {N{1'b1}};
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({m_valid, s_ready, busy, timeout_pulse} !== 7'b0) begin
                errors++;
                $display("FAIL reset_tx: got v=%b rdy=%b busy=%b to=%b, want all 0", m_valid, s_ready, busy, timeout_pulse);
            end
            checks++;
            if ({o_valid, r_ready} !== 5'b0) begin
                errors++;
                $display("FAIL reset_rx: got o_valid=%b r_ready=%b, want 0", o_valid, r_ready);
            end
        end
        r_valid = 1'b0;
        o_ready = {N{1'b0}};
        do_reset();
    endtask

    task automatic test_single();
        obs_log.delete();
        gap_pct = 0;
        m_ready = 1'b1;
        q[2].push_back({1'b0, 32'h0000_0011});
        q[2].push_back({1'b0, 32'h0000_0022});
        q[2].push_back({1'b1, 32'h0000_0033});
        for (int i = 0; i < 6; i++) begin
            step_pre();
            checks++;
            if ({m_valid, s_ready, busy, obs_pay} !== {exp_m_valid, exp_s_ready, exp_busy, exp_pay}) begin
                errors++;
                $display("FAIL single_tx cyc %0d: got v=%b rdy=%b busy=%b pay=%h, want v=%b rdy=%b busy=%b pay=%h", i, m_valid, s_ready, busy, obs_pay, exp_m_valid, exp_s_ready, exp_busy, exp_pay);
            end
            if (i == 0 || i == 4) begin
                checks++;
                if ({m_valid, busy} !== 2'b00) begin
                    errors++;
                    $display("FAIL single_idle cyc %0d: got v=%b busy=%b, want 0 0", i, m_valid, busy);
                end
            end
            step_post();
        end
        checks++;
        if (obs_log.size() != 3 || obs_log[0] !== {1'b0, 2'd2, 32'h0000_0011} ||
            obs_log[1] !== {1'b0, 2'd2, 32'h0000_0022} || obs_log[2] !== {1'b1, 2'd2, 32'h0000_0033}) begin
            errors++;
            $display("FAIL single_beats: got %0d beats, want 3 beats 11/22/33 with dest 2", obs_log.size());
        end
    endtask

    task automatic test_contention();
        int got_cnt;
        int order_code;
        do_reset();
        obs_log.delete();
        for (int p = 0; p < 2; p++) begin
            q[0].push_back({1'b0, 32'(32'hA0 + p)});
            q[0].push_back({1'b1, 32'(32'hA8 + p)});
        end
        q[3].push_back({1'b0, 32'h0000_00C0});
        q[3].push_back({1'b1, 32'h0000_00C1});
        for (int i = 0; i < 12; i++) begin
            step_pre();
            checks++;
            if ({m_valid, s_ready, busy, obs_pay} !== {exp_m_valid, exp_s_ready, exp_busy, exp_pay}) begin
                errors++;
                $display("FAIL contention_tx cyc %0d: got v=%b rdy=%b busy=%b pay=%h, want v=%b rdy=%b busy=%b pay=%h", i, m_valid, s_ready, busy, obs_pay, exp_m_valid, exp_s_ready, exp_busy, exp_pay);
            end
            step_post();
        end
        got_cnt    = 0;
        order_code = 0;
        foreach (obs_log[j]) begin
            if (obs_log[j][DW+DSW]) begin
                got_cnt++;
                order_code = order_code * 16 + int'(obs_log[j][DW+DSW-1:DW]);
            end
        end
        checks++;
        if (got_cnt != 3 || order_code != 32'h030 || obs_log.size() != 6) begin
            errors++;
            $display("FAIL contention_order: got %0d packets order %h beats %0d, want 3 packets order 030 beats 6", got_cnt, order_code, obs_log.size());
        end
    endtask

    task automatic test_backpressure();
        obs_log.delete();
        for (int j = 0; j < 4; j++) q[1].push_back({(j == 3), 32'(32'hB0 + j)});
        for (int i = 0; i < 10; i++) begin
            m_ready = (i % 2 == 1);
            step_pre();
            checks++;
            if ({m_valid, s_ready, busy, obs_pay} !== {exp_m_valid, exp_s_ready, exp_busy, exp_pay}) begin
                errors++;
                $display("FAIL bp_tx cyc %0d: got v=%b rdy=%b busy=%b pay=%h, want v=%b rdy=%b busy=%b pay=%h", i, m_valid, s_ready, busy, obs_pay, exp_m_valid, exp_s_ready, exp_busy, exp_pay);
            end
            checks++;
            if (s_ready !== {2'b00, m_ready & (mdl_owner == 1), 1'b0}) begin
                errors++;
                $display("FAIL bp_sready cyc %0d: got %b, want %b", i, s_ready, {2'b00, m_ready & (mdl_owner == 1), 1'b0});
            end
            step_post();
        end
        checks++;
        if (obs_log.size() != 4 || obs_log[0] !== {1'b0, 2'd1, 32'h0000_00B0} || obs_log[1] !== {1'b0, 2'd1, 32'h0000_00B1} ||
            obs_log[2] !== {1'b0, 2'd1, 32'h0000_00B2} || obs_log[3] !== {1'b1, 2'd1, 32'h0000_00B3}) begin
            errors++;
            $display("FAIL bp_beats: got %0d beats, want 4 beats B0..B3 on dest 1", obs_log.size());
        end
    endtask

    task automatic test_return();
        m_ready = 1'b1;
        r_valid = 1'b1;
        r_dest  = 2'd1;
        r_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            o_ready = (i < 2) ? 4'b0000 : 4'b0010;
            step_pre();
            checks++;
            if ({o_valid, r_ready, o_data} !== {4'b0010, (i == 2), 32'hDEAD_BEEF}) begin
                errors++;
                $display("FAIL return_demux cyc %0d: got o_valid=%b r_ready=%b o_data=%h, want 0010 %b deadbeef", i, o_valid, r_ready, o_data, (i == 2));
            end
            step_post();
        end
        r_valid = 1'b0;
        o_ready = 4'b0000;
    endtask

    task automatic test_reset_mid();
        int n;
        obs_log.delete();
        m_ready = 1'b1;
        for (int j = 0; j < 4; j++) q[1].push_back({(j == 3), 32'(32'hD0 + j)});
        n = 0;
        while (obs_log.size() < 2 && n < 10) begin
            step_pre();
            step_post();
            n++;
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_valid, busy, s_ready} !== 6'b0 || obs_log.size() != 2) begin
            errors++;
            $display("FAIL reset_mid_async: got v=%b busy=%b rdy=%b beats=%0d, want 0 0 0000 beats=2", m_valid, busy, s_ready, obs_log.size());
        end
        do_reset();
        obs_log.delete();
        q[3].push_back({1'b0, 32'h0000_00E0});
        q[3].push_back({1'b1, 32'h0000_00E1});
        for (int i = 0; i < 5; i++) begin
            step_pre();
            checks++;
            if ({m_valid, s_ready, busy, obs_pay} !== {exp_m_valid, exp_s_ready, exp_busy, exp_pay}) begin
                errors++;
                $display("FAIL reset_mid_tx cyc %0d: got v=%b rdy=%b busy=%b pay=%h, want v=%b rdy=%b busy=%b pay=%h", i, m_valid, s_ready, busy, obs_pay, exp_m_valid, exp_s_ready, exp_busy, exp_pay);
            end
            step_post();
        end
        checks++;
        if (obs_log.size() != 2 || obs_log[0] !== {1'b0, 2'd3, 32'h0000_00E0}) begin
            errors++;
            $display("FAIL reset_mid_grant: got %0d beats, want ch3 packet E0/E1", obs_log.size());
        end
    endtask

    task automatic test_random();
        gap_pct = 25;
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) begin
                if (q[c].size() == 0 && $urandom_range(9) == 0) begin
                    int len = int'($urandom_range(1, 4));
                    for (int b = 0; b < len; b++) q[c].push_back({(b == len - 1), 32'($urandom)});
                end
            end
            m_ready = ($urandom_range(9) < 7);
            r_valid = 1'($urandom_range(1));
            r_dest  = 2'($urandom_range(3));
            r_data  = $urandom;
            o_ready = 4'($urandom_range(15));
            step_pre();
            checks++;
            if ({m_valid, s_ready, busy, obs_pay} !== {exp_m_valid, exp_s_ready, exp_busy, exp_pay}) begin
                errors++;
                $display("FAIL rand_tx cyc %0d: got v=%b rdy=%b busy=%b pay=%h, want v=%b rdy=%b busy=%b pay=%h", i, m_valid, s_ready, busy, obs_pay, exp_m_valid, exp_s_ready, exp_busy, exp_pay);
            end
            checks++;
            if ({o_valid, r_ready, o_data} !== {exp_o_valid, exp_r_ready, r_data}) begin
                errors++;
                $display("FAIL rand_rx cyc %0d: got o_valid=%b r_ready=%b o_data=%h, want %b %b %h", i, o_valid, r_ready, o_data, exp_o_valid, exp_r_ready, r_data);
            end
            step_post();
        end
        gap_pct = 0;
        r_valid = 1'b0;
    endtask

`ifdef TCP_CHAN_ARBITER_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int first_pulse;
        int pulses;
        do_reset();
        obs_log.delete();
        gap_pct = 0;
        m_ready = 1'b1;
        for (int j = 0; j < 4; j++) q[0].push_back({(j == 3), 32'(32'hF0 + j)});
        n = 0;
        while (obs_log.size() < 2 && n < 10) begin
            step_pre();
            step_post();
            n++;
        end
        hold[0] = 1'b1;
        q[1].push_back({1'b1, 32'h0000_0F11});
        first_pulse = -1;
        pulses      = 0;
        for (int i = 0; i < 14; i++) begin
            step_pre();
            if (timeout_pulse === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
            step_post();
        end
        checks++;
        if (first_pulse != 8 || pulses != 1) begin
            errors++;
            $display("FAIL timeout_pulse: got first at stall cycle %0d, %0d pulses, want cycle 8 and 1 pulse", first_pulse, pulses);
        end
        checks++;
        if (obs_log.size() != 3 || obs_log[2] !== {1'b1, 2'd1, 32'h0000_0F11}) begin
            errors++;
            $display("FAIL timeout_regrant: got %0d beats, want ch1 beat 0f11 after 2 ch0 beats", obs_log.size());
        end
    endtask
`endif

    initial begin
        rst       = 1'b1;
        s_valid   = {N{1'b0}};
        s_last    = {N{1'b0}};
        s_data    = {(N*DW){1'b0}};
        m_ready   = 1'b0;
        r_valid   = 1'b0;
        r_data    = 32'h0;
        r_dest    = 2'd0;
        o_ready   = {N{1'b0}};
        hold      = {N{1'b0}};
        gap_pct   = 0;
        mdl_owner = -1;
        mdl_ptr   = 0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_return();
        test_reset_mid();
        test_random();
`ifdef TCP_CHAN_ARBITER_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
